// File: rtl/pen_lift_sequencer.sv
// Pen-lift command sequencer: accepts one servo position command at a time and
// holds off completion for a programmable number of clk_en ticks while the horn settles.
//
// state  | meaning
// IDLE   | ready for a command, pos holds the last commanded position
// SETTLE | new position driven, counting clk_en ticks down to 1
// DONE   | one-cycle completion pulse, then back to IDLE
module pen_lift_sequencer #(
  parameter int SETTLE_BITS = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clk_en,
  input  logic [SETTLE_BITS-1:0] settle_ticks,
  input  logic                   cmd_valid,
  input  logic                   cmd_pos,
  output logic                   cmd_ready,
  output logic                   pos,
  output logic                   busy,
  output logic                   done
);

  localparam logic SERVO_POS_UP   = 1'b0;
  localparam logic SERVO_POS_DOWN = 1'b1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [SETTLE_BITS-1:0] cnt_q, cnt_d;
  logic                   pos_q, pos_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          pos_d = cmd_pos;
          // A command to the current position needs no settle time.
          if ((cmd_pos == pos_q) || (settle_ticks == '0)) begin
            state_d = ST_DONE;
          end else begin
            cnt_d   = settle_ticks;
            state_d = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        if (clk_en) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == {{(SETTLE_BITS-1){1'b0}}, 1'b1}) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pos_q   <= SERVO_POS_UP;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_SETTLE) || (state_q == ST_DONE);
  assign done      = (state_q == ST_DONE);
  assign pos       = pos_q;

  logic unused_down;
  assign unused_down = SERVO_POS_DOWN;

endmodule

// File: doc/pen_lift_sequencer.md
# pen_lift_sequencer

Sequences pen-lift commands from the motion processor into the servo position consumed by `ServoCtrl`. It accepts one up/down command at a time over a valid/ready handshake, drives the new position immediately, then holds off completion for a programmable number of clock-enable ticks so the SG90 horn has physically settled before the next plotting move starts. It sits directly upstream of `ServoCtrl`; its `pos` output connects to `ServoCtrl.pos`.

## Interface
- `SETTLE_BITS`, default 16: width of the settle-tick counter and of `settle_ticks`.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `clk_en`  in  1  settle timebase tick, one-cycle pulse from a `ClockEnabler`.
- `settle_ticks`  in  SETTLE_BITS  settle time in `clk_en` ticks; sampled only on command accept.
- `cmd_valid`  in  1  command present.
- `cmd_pos`  in  `Servo::ServoPosition_t`  requested pen position.
- `cmd_ready`  out  1  block can accept a command.
- `pos`  out  `Servo::ServoPosition_t`  current commanded servo position, to `ServoCtrl`.
- `busy`  out  1  command in progress (SETTLE or DONE).
- `done`  out  1  one-cycle pulse when the command has completed.

## Operation
- States: IDLE, SETTLE, DONE. All outputs are registered or decoded from the state register only. There are no combinational paths from inputs to outputs.
- Reset (`reset` low, asynchronous):
  - state = IDLE, `pos` = `SERVO_POS_UP` (pen up is the safe position), counter = 0.
  - `cmd_ready` = 1, `busy` = 0, `done` = 0.
- IDLE:
  - `cmd_ready` = 1.
  - Accept occurs on a rising edge with `cmd_valid` && `cmd_ready`. On accept:
    - `pos` <= `cmd_pos`.
    - If `cmd_pos` == current `pos`, or `settle_ticks` == 0, go to DONE. No settle is applied.
    - Otherwise counter <= `settle_ticks`, go to SETTLE.
- SETTLE:
  - `cmd_ready` = 0, `busy` = 1.
  - On each edge with `clk_en` = 1, counter decrements by 1.
  - On the edge where counter == 1 and `clk_en` = 1, go to DONE.
  - `cmd_valid` and `cmd_pos` are ignored. The upstream side must hold the next command until `cmd_ready`.
- DONE:
  - `done` = 1, `busy` = 1, `cmd_ready` = 0, for exactly one cycle.
  - Next state is always IDLE.
- `settle_ticks` changing after accept has no effect on the command in flight.
- Counter arithmetic is unsigned SETTLE_BITS. It never underflows, because SETTLE is entered only with a nonzero count.

## Timing
- Accept at edge A:
  - `pos` takes the new value in the cycle after A.
  - `cmd_ready` is low from the cycle after A.
- A `clk_en` pulse coincident with edge A is not counted.
- Settle duration: with T > 0 and the position changing, DONE is entered on the T-th `clk_en` edge strictly after A. `done` is high in the cycle after that edge.
- No-move or T = 0: `done` is high in the cycle after A. Total is 2 cycles from accept to the next `cmd_ready`.
- `cmd_ready` returns to 1 in the cycle after `done`.
- Minimum command spacing is therefore 2 cycles, plus T `clk_en` periods when the position moves.
- `clk_en` held constantly high: a move with T ticks spends exactly T cycles in SETTLE.
- Reset asserted mid-SETTLE or mid-DONE:
  - Immediate return to IDLE with `pos` = UP.
  - No `done` pulse.
  - Operation resumes on the first edge after `reset` deasserts.
- `pos` never changes except on accept or reset.

## Test plan
- Reset, then idle: `reset` low then high → `pos` = UP, `cmd_ready` = 1, `busy` = 0, `done` = 0, and all hold indefinitely with `cmd_valid` = 0.
- Move with settle: `settle_ticks` = 3, `clk_en` every 4th cycle, send DOWN from UP → `pos` = DOWN the next cycle; `done` pulses once, the cycle after the 3rd `clk_en` following accept; `cmd_ready` goes high one cycle after that.
- No-move command: `pos` = UP, send UP with `settle_ticks` = 100 → `done` the cycle after accept; back to ready 2 cycles after accept; `clk_en` ignored.
- Zero settle: `settle_ticks` = 0, send DOWN from UP → `pos` = DOWN and `done` both in the cycle after accept.
- Backpressure: hold `cmd_valid` = 1 with alternating `cmd_pos` during SETTLE → no accept and `pos` unchanged until `cmd_ready`; the next command is accepted on the first ready cycle.
- Reset mid-settle: `settle_ticks` = 10, send DOWN, pulse `reset` low after 4 ticks → `pos` = UP immediately; no `done`; a new DOWN command afterwards takes the full 10 ticks.
